// File: rtl/shift_sequencial.sv
// shift_sequencial: multi-cycle shifter doing SLL/SRL/SRA/ROL, at most PASSO positions per clock.
module shift_sequencial #(
  parameter int LARGURA = 32,
  parameter int PASSO = 1,
  localparam int QW = $clog2(LARGURA)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inicio,
  input  logic [1:0]         modo,
  input  logic [QW-1:0]      quantidade,
  input  logic [LARGURA-1:0] sinal,
  output logic [LARGURA-1:0] sinal_deslocado,
  output logic               ocupado,
  output logic               pronto
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [LARGURA-1:0] dado_q, dado_d, desloc, rol;
  logic [QW-1:0] resto_q, resto_d, passo;
  logic [1:0] modo_q, modo_d;
  // PASSO can exceed the QW range, but then resto_q is always the smaller value
  assign passo = (int'(resto_q) < PASSO) ? resto_q : QW'(PASSO);
  assign rol = (dado_q << passo) | (dado_q >> (LARGURA - int'(passo)));
  assign desloc = modo_q == 2'd0 ? dado_q << passo :
                  modo_q == 2'd1 ? dado_q >> passo :
                  modo_q == 2'd2 ? $unsigned($signed(dado_q) >>> passo) : rol;
  always_comb begin
    state_d = state_q;
    dado_d = dado_q;
    resto_d = resto_q;
    modo_d = modo_q;
    if (state_q == IDLE && inicio) begin
      dado_d = sinal;
      resto_d = quantidade;
      modo_d = modo;
      state_d = quantidade == '0 ? DONE : SHIFT;
    end else if (state_q == SHIFT) begin
      dado_d = desloc;
      resto_d = resto_q - passo;
      state_d = resto_d == '0 ? DONE : SHIFT;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dado_q <= '0;
      resto_q <= '0;
      modo_q <= '0;
    end else begin
      state_q <= state_d;
      dado_q <= dado_d;
      resto_q <= resto_d;
      modo_q <= modo_d;
    end
  end
  assign sinal_deslocado = dado_q;
  assign ocupado = state_q != IDLE;
  assign pronto = state_q == DONE;
endmodule

// File: tb/tb_shift_sequencial.sv
// tb_shift_sequencial: four lanes (PASSO 1,3,4,32) driven by cycle-scheduled stimulus, scoreboard-checked.
module tb_shift_sequencial;
  localparam int NR = 340;
  typedef struct {logic [31:0] v; int c;} exp_t;
  logic clock = 0;
  logic reset = 1;
  logic rel = 0;
  logic go = 0;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int fin_cnt = 0;
  logic [31:0] res [4];
  logic [3:0] oc, pr;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Reference: each result bit picked directly from its source bit position.
  function automatic logic [31:0] ref_op(logic [31:0] x, logic [1:0] m, int k);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = m == 2'd0 ? (i >= k ? x[(i - k) % 32] : 1'b0) :
             m == 2'd3 ? x[(i + 32 - k) % 32] :
             (i + k < 32 ? x[(i + k) % 32] : (m == 2'd2 ? x[31] : 1'b0));
    return r;
  endfunction
  for (genvar g = 0; g < 4; g++) begin : lane
    localparam int P = g == 0 ? 1 : g == 1 ? 3 : g == 2 ? 4 : 32;
    logic ini;
    logic [1:0] md;
    logic [4:0] qt;
    logic [31:0] sg;
    exp_t sb[$];
    int bf = 1;
    int bu = 0;
    logic [31:0] ds [6] = '{32'h4, 32'h80000000, 32'h80000000, 32'h1234ABCD, 32'h1, 32'h80000001};
    logic [1:0] dm [6] = '{2'd0, 2'd2, 2'd1, 2'd3, 2'd0, 2'd3};
    int dq [6] = '{1, 4, 4, 0, 3, 9};
    logic [31:0] de [6] = '{32'h8, 32'hF8000000, 32'h08000000, 32'h1234ABCD, 32'h8, 32'h300};
    shift_sequencial #(.LARGURA(32), .PASSO(P)) dut (
      .clock(clock), .reset(reset), .inicio(ini), .modo(md), .quantidade(qt), .sinal(sg),
      .sinal_deslocado(res[g]), .ocupado(oc[g]), .pronto(pr[g])
    );
    always @(negedge clock) begin
      if (rel) begin
        if (go) chk($sformatf("lane%0d_ocupado", g), 32'(oc[g]), 32'(cyc >= bf && cyc <= bu));
        if (pr[g]) begin
          if (sb.size() == 0) chk($sformatf("lane%0d_unexpected_pronto", g), 32'(pr[g]), 32'd0);
          else begin
            chk($sformatf("lane%0d_result", g), res[g], sb[0].v);
            chk($sformatf("lane%0d_latency", g), 32'(cyc), 32'(sb[0].c));
            void'(sb.pop_front());
          end
        end else if (sb.size() != 0 && sb[0].c < cyc) begin
          chk($sformatf("lane%0d_missing_pronto", g), 32'(pr[g]), 32'd1);
          void'(sb.pop_front());
        end
      end
    end
    initial begin
      int na, idf, k, n;
      logic [31:0] x, e;
      logic [1:0] m;
      ini = 0; md = 0; qt = 0; sg = 0;
      wait (rel);
      // long op to be aborted by the reset pulse; PASSO=32 would finish before it
      if (P < 8) begin
        ini = 1; md = 2'd0; qt = 5'd20; sg = 32'h1;
      end
      @(negedge clock); #1;
      ini = 0;
      wait (go);
      na = cyc + 1;
      idf = cyc + 1;
      for (int i = 0; i < 6 + NR; i++) begin
        if (i < 6) begin
          x = ds[i]; m = dm[i]; k = dq[i]; e = de[i];
        end else begin
          x = $urandom; m = 2'($urandom_range(0, 3)); k = $urandom_range(0, 31); e = ref_op(x, m, k);
          if ($urandom_range(0, 3) == 0) na += $urandom_range(1, 2);
        end
        while (cyc + 1 != na) begin
          ini = (cyc + 1 < idf) ? ($urandom_range(0, 3) != 0) : 1'b0;
          md = 2'($urandom_range(0, 3)); qt = 5'($urandom_range(0, 31)); sg = $urandom;
          @(negedge clock); #1;
        end
        ini = 1; md = m; qt = 5'(k); sg = x;
        n = (k + P - 1) / P;
        sb.push_back('{e, na + n});
        bf = na;
        bu = na + n;
        idf = na + n + 2;
        na = idf;
        @(negedge clock); #1;
      end
      ini = 0;
      while (cyc < idf + 1) begin
        @(negedge clock); #1;
      end
      chk($sformatf("lane%0d_scoreboard_empty", g), 32'(sb.size()), 32'd0);
      fin_cnt++;
    end
  end
  initial begin
    repeat (3) @(negedge clock);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_result%0d", g), res[g], 32'd0);
      chk($sformatf("reset_ocupado%0d", g), 32'(oc[g]), 32'd0);
      chk($sformatf("reset_pronto%0d", g), 32'(pr[g]), 32'd0);
    end
    #1 reset = 0;
    rel = 1;
    repeat (4) @(negedge clock);
    chk("busy_before_abort", 32'(oc[0]), 32'd1);
    #2 reset = 1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("async_reset_result%0d", g), res[g], 32'd0);
      chk($sformatf("async_reset_ocupado%0d", g), 32'(oc[g]), 32'd0);
      chk($sformatf("async_reset_pronto%0d", g), 32'(pr[g]), 32'd0);
    end
    @(negedge clock); #1;
    reset = 0;
    repeat (3) @(negedge clock);
    #1 go = 1;
    for (int i = 0; i < 30000 && fin_cnt < 4; i++) @(negedge clock);
    if (fin_cnt < 4) chk("timeout_lanes_finished", 32'(fin_cnt), 32'd4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_sequencial.md
SHIFT_SEQUENCIAL -- requirements
Module: shift_sequencial

Interface
REQ-001 Parameter LARGURA, default 32, data width in bits; the block SHALL support any LARGURA >= 2.
REQ-002 Parameter PASSO, default 1, maximum shift positions applied per clock cycle; the block SHALL support 1 <= PASSO <= LARGURA.
REQ-003 Derived QW = $clog2(LARGURA) SHALL be the width of the shift-amount port.
REQ-004 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 inicio  input  1  start request, sampled on the rising edge.
REQ-007 modo  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-008 quantidade  input  QW  shift amount, unsigned, 0..LARGURA-1.
REQ-009 sinal  input  LARGURA  operand.
REQ-010 sinal_deslocado  output  LARGURA  working/result register.
REQ-011 ocupado  output  1  high whenever the state is not IDLE.
REQ-012 pronto  output  1  high for exactly one cycle, in state DONE.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-014 In IDLE, inicio=1 at an edge SHALL latch sinal into sinal_deslocado, and latch modo and quantidade into a remaining-count register.
REQ-015 On that edge, the FSM SHALL go to DONE if quantidade=0; otherwise it SHALL go to SHIFT.
REQ-016 Each SHIFT edge SHALL shift sinal_deslocado by s = min(PASSO, remaining) positions in the latched modo, and decrement remaining by s.
REQ-017 The SHIFT edge that makes remaining 0 SHALL move the FSM to DONE.
REQ-018 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-019 Latency: with the start accepted at edge k, pronto SHALL be high in the cycle after edge k+ceil(quantidade/PASSO); quantidade=0 gives pronto right after edge k.
REQ-020 SLL SHALL shift left with zero fill.
REQ-021 SRL SHALL shift right with zero fill.
REQ-022 SRA SHALL shift right, replicating the latched MSB.
REQ-023 ROL SHALL rotate left, with the MSB wrapping to the LSB.
REQ-024 The result SHALL equal the single-step combinational result for every modo, quantidade and PASSO.
REQ-025 inicio SHALL be ignored in SHIFT and DONE; changes on sinal, modo or quantidade during an operation SHALL have no effect.
REQ-026 A start SHALL be accepted no earlier than the edge after DONE, i.e. back-to-back operations spaced by one IDLE cycle.
REQ-027 sinal_deslocado SHALL hold the last result in IDLE until the next accepted start overwrites it.
REQ-028 Intermediate values of sinal_deslocado during SHIFT are visible but not valid; consumers SHALL sample only when pronto=1.

Reset
REQ-029 reset=1 SHALL immediately, without waiting for a clock edge, force state IDLE, sinal_deslocado=0, remaining=0, ocupado=0 and pronto=0.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no pronto pulse SHALL follow.
REQ-031 The first start SHALL be accepted at the first edge with reset=0 and inicio=1.

Verification
REQ-032 LARGURA=32, PASSO=1, modo=00, sinal=0x00000004, quantidade=1 -> pronto one cycle after the start edge, sinal_deslocado=0x00000008, ocupado high for 2 cycles.
REQ-033 LARGURA=32, PASSO=1, modo=10, sinal=0x80000000, quantidade=4 -> pronto after 4 shift edges, result=0xF8000000; same stimulus with modo=01 -> 0x08000000.
REQ-034 LARGURA=32, PASSO=4, modo=11, sinal=0x80000001, quantidade=9 -> steps 4,4,1, pronto after 3 shift edges, result=0x00000300.
REQ-035 quantidade=0, any modo, sinal=0x1234ABCD -> pronto right after the start edge, result=0x1234ABCD.
REQ-036 Pulse reset during SHIFT of a quantidade=20 operation -> all outputs 0 asynchronously, no pronto; a following start with sinal=0x1, SLL by 3 -> 0x00000008.
REQ-037 Hold inicio=1 continuously and change sinal mid-operation -> the result reflects only the value latched at acceptance, the next start is accepted one cycle after DONE, and a random compare against the reference model over 1000 operations (PASSO in {1,3,32}) shows no mismatch.
